// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and types for the memory/writeback stage of the 8-bit pipeline.
package mem_wb_stage_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam int REG_W  = 5;

    // Memory-mapped I/O addresses; they shadow the top two data-memory words.
    localparam logic [ADDR_W-1:0] IO_OUT_ADDR = 8'hFF;
    localparam logic [ADDR_W-1:0] IO_IN_ADDR  = 8'hFE;

    // Control encodings carried down from execute.
    localparam logic MEM_WRITE  = 1'b1;
    localparam logic MEM_READ   = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;
    localparam logic WB_SEL_ALU = 1'b0;

    // Writeback record as seen by the register file and the forwarding tap.
    typedef struct packed {
        logic [DATA_W-1:0] ans;
        logic [REG_W-1:0]  rw;
        logic              we;
    } wb_rec_t;

    // Picks the writeback value: memory/IO data only for a real load with mem select.
    function automatic logic [DATA_W-1:0] wb_select(
        input logic              sel_mem,
        input logic              is_load,
        input logic [DATA_W-1:0] rdata,
        input logic [DATA_W-1:0] alu
    );
        logic [DATA_W-1:0] res;
        if (sel_mem == WB_SEL_MEM && is_load) begin
            res = rdata;
        end else begin
            res = alu;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle of execute-side inputs, I/O port and writeback/forwarding outputs.
interface mem_wb_stage_if;
    import mem_wb_stage_pkg::*;

    logic [DATA_W-1:0] ans_ex;
    logic [DATA_W-1:0] B_Bypass;
    logic              mem_en_ex;
    logic              mem_rw_ex;
    logic              mem_mux_sel_ex;
    logic [REG_W-1:0]  RW_ex;
    logic [DATA_W-1:0] port_in;
    logic [DATA_W-1:0] port_out;
    logic [DATA_W-1:0] ans_wb;
    logic [REG_W-1:0]  RW_wb;
    logic              reg_we_wb;
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_RW;
    logic [DATA_W-1:0] fwd_data;
    logic [DATA_W-1:0] store_cnt;

    // Upstream side: execute stage plus the external world driving port_in.
    modport master (
        output ans_ex, B_Bypass, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, RW_ex, port_in,
        input  port_out, ans_wb, RW_wb, reg_we_wb, fwd_valid, fwd_RW, fwd_data, store_cnt
    );

    // The memory/writeback stage itself.
    modport slave (
        input  ans_ex, B_Bypass, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, RW_ex, port_in,
        output port_out, ans_wb, RW_wb, reg_we_wb, fwd_valid, fwd_RW, fwd_data, store_cnt
    );

endinterface

// File: rtl/mem_wb_stage_data_mem_sp.sv
// Single-port data memory: synchronous write, asynchronous read, contents never reset.
module data_mem_sp
    import mem_wb_stage_pkg::*;
#(
    parameter int MEM_DEPTH  = DEPTH,
    parameter int MEM_DATA_W = DATA_W,
    parameter int MEM_ADDR_W = ADDR_W
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [MEM_ADDR_W-1:0] addr_i,
    input  logic [MEM_DATA_W-1:0] wdata_i,
    output logic [MEM_DATA_W-1:0] rdata_o
);

    logic [MEM_DATA_W-1:0] mem_q [MEM_DEPTH];

    // Write port: the array updates on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Combinational read sees the old word during a same-edge write.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: data-memory access, memory-mapped I/O, store counter
// and the registered writeback record that also feeds the forwarding tap.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mem_wb_stage_if.slave bus
);

    logic              store_s;
    logic              load_s;
    logic [ADDR_W-1:0] addr_s;
    logic              io_out_hit_s;
    logic              io_in_hit_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_rdata_s;
    logic [DATA_W-1:0] rdata_s;

    logic [DATA_W-1:0] ans_wb_d,    ans_wb_q;
    logic [REG_W-1:0]  rw_wb_d,     rw_wb_q;
    logic              reg_we_wb_d, reg_we_wb_q;
    logic [DATA_W-1:0] port_out_d,  port_out_q;
    logic [DATA_W-1:0] store_cnt_d, store_cnt_q;

    data_mem_sp #(
        .MEM_DEPTH  (DEPTH),
        .MEM_DATA_W (DATA_W),
        .MEM_ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk     (clk),
        .we_i    (mem_we_s),
        .addr_i  (addr_s),
        .wdata_i (bus.B_Bypass),
        .rdata_o (mem_rdata_s)
    );

    // Decode the access type, I/O address hits and the memory write strobe.
    always_comb begin
        store_s      = bus.mem_en_ex & (bus.mem_rw_ex == MEM_WRITE);
        load_s       = bus.mem_en_ex & (bus.mem_rw_ex == MEM_READ);
        addr_s       = bus.ans_ex[ADDR_W-1:0];
        io_out_hit_s = (addr_s == IO_OUT_ADDR);
        io_in_hit_s  = (addr_s == IO_IN_ADDR);
        // A store in a reset cycle is dropped, so memory must not see it either.
        mem_we_s     = store_s & ~io_out_hit_s & ~reset;
        if (io_in_hit_s) begin
            rdata_s = bus.port_in;
        end else begin
            rdata_s = mem_rdata_s;
        end
    end

    // Next-state for the writeback record, output port and store counter.
    always_comb begin
        ans_wb_d    = wb_select(bus.mem_mux_sel_ex, load_s, rdata_s, bus.ans_ex);
        rw_wb_d     = bus.RW_ex;
        reg_we_wb_d = ~store_s;
        if (store_s && io_out_hit_s) begin
            port_out_d = bus.B_Bypass;
        end else begin
            port_out_d = port_out_q;
        end
        if (store_s) begin
            store_cnt_d = store_cnt_q + 8'd1;
        end else begin
            store_cnt_d = store_cnt_q;
        end
    end

    // Pipeline registers; synchronous reset wins over any activity this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ans_wb_q    <= 8'h00;
            rw_wb_q     <= 5'd0;
            reg_we_wb_q <= 1'b0;
            port_out_q  <= 8'h00;
            store_cnt_q <= 8'h00;
        end else begin
            ans_wb_q    <= ans_wb_d;
            rw_wb_q     <= rw_wb_d;
            reg_we_wb_q <= reg_we_wb_d;
            port_out_q  <= port_out_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign bus.ans_wb    = ans_wb_q;
    assign bus.RW_wb     = rw_wb_q;
    assign bus.reg_we_wb = reg_we_wb_q;
    assign bus.port_out  = port_out_q;
    assign bus.store_cnt = store_cnt_q;
    // The forwarding tap is exactly the registered writeback record.
    assign bus.fwd_valid = reg_we_wb_q;
    assign bus.fwd_RW    = rw_wb_q;
    assign bus.fwd_data  = ans_wb_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: each issued cycle pushes its expected
// writeback record; a monitor pops and compares one record after each edge.
module tb_mem_wb_stage;

    logic clk;
    logic reset;

    mem_wb_stage_if bus ();

    mem_wb_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ans;
        logic       chk_ans;
        logic [4:0] rw;
        logic       we;
        logic [7:0] port;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb_q [$];
    exp_t       mon_e;
    int         n_vec;
    int         n_err;

    // Reference state
    logic [7:0]   mem_m [256];
    logic [255:0] known_m;
    logic [7:0]   port_m;
    logic [7:0]   cnt_m;

    // Drive one cycle of stimulus and push what the stage must show after the edge.
    task automatic issue(input logic rst, input logic en, input logic rw,
                         input logic sel, input logic [7:0] ans,
                         input logic [7:0] b, input logic [4:0] rwex);
        exp_t e;
        logic st;
        logic ld;
        reset              = rst;
        bus.mem_en_ex      = en;
        bus.mem_rw_ex      = rw;
        bus.mem_mux_sel_ex = sel;
        bus.ans_ex         = ans;
        bus.B_Bypass       = b;
        bus.RW_ex          = rwex;
        st = en & rw;
        ld = en & ~rw;
        e.chk_ans = 1'b1;
        if (rst) begin
            e.ans  = 8'h00;
            e.rw   = 5'd0;
            e.we   = 1'b0;
            port_m = 8'h00;
            cnt_m  = 8'h00;
        end else begin
            e.rw = rwex;
            e.we = ~st;
            if (sel && ld) begin
                if (ans == 8'hFE) begin
                    e.ans = bus.port_in;
                end else if (ans != 8'hFF && known_m[ans]) begin
                    e.ans = mem_m[ans];
                end else begin
                    e.ans     = 8'h00;
                    e.chk_ans = 1'b0;
                end
            end else begin
                e.ans = ans;
            end
            if (st) begin
                if (ans == 8'hFF) begin
                    port_m = b;
                end else begin
                    mem_m[ans]   = b;
                    known_m[ans] = 1'b1;
                end
                cnt_m = cnt_m + 8'd1;
            end
        end
        e.port = port_m;
        e.cnt  = cnt_m;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: one scoreboard entry is retired just after every rising edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_vec = n_vec + 1;
            if (mon_e.chk_ans && (bus.ans_wb !== mon_e.ans || bus.fwd_data !== mon_e.ans)) begin
                n_err = n_err + 1;
                $display("FAIL sb_ans: ans_wb=%h fwd_data=%h expected %h at %0t",
                         bus.ans_wb, bus.fwd_data, mon_e.ans, $time);
            end
            n_vec = n_vec + 1;
            if (bus.RW_wb !== mon_e.rw || bus.fwd_RW !== mon_e.rw) begin
                n_err = n_err + 1;
                $display("FAIL sb_rw: RW_wb=%0d fwd_RW=%0d expected %0d at %0t",
                         bus.RW_wb, bus.fwd_RW, mon_e.rw, $time);
            end
            n_vec = n_vec + 1;
            if (bus.reg_we_wb !== mon_e.we || bus.fwd_valid !== mon_e.we) begin
                n_err = n_err + 1;
                $display("FAIL sb_we: reg_we_wb=%b fwd_valid=%b expected %b at %0t",
                         bus.reg_we_wb, bus.fwd_valid, mon_e.we, $time);
            end
            n_vec = n_vec + 1;
            if (bus.port_out !== mon_e.port || bus.store_cnt !== mon_e.cnt) begin
                n_err = n_err + 1;
                $display("FAIL sb_io: port_out=%h store_cnt=%h expected %h/%h at %0t",
                         bus.port_out, bus.store_cnt, mon_e.port, mon_e.cnt, $time);
            end
        end
    end

    task automatic test_reset();
        issue(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0);
        issue(1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 8'h11, 5'd1);
        issue(1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 8'hAA, 5'd9);
        issue(1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 8'hAA, 5'd9);
        n_vec = n_vec + 1;
        if (bus.ans_wb !== 8'h00 || bus.RW_wb !== 5'd0 || bus.reg_we_wb !== 1'b0 ||
            bus.port_out !== 8'h00 || bus.store_cnt !== 8'h00) begin
            n_err = n_err + 1;
            $display("FAIL reset_state: ans=%h rw=%0d we=%b port=%h cnt=%h expected all zero",
                     bus.ans_wb, bus.RW_wb, bus.reg_we_wb, bus.port_out, bus.store_cnt);
        end
        issue(1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 5'd2);
        n_vec = n_vec + 1;
        if (bus.ans_wb !== 8'h11) begin
            n_err = n_err + 1;
            $display("FAIL reset_drop: load 20 got %h expected 11", bus.ans_wb);
        end
    endtask

    task automatic test_store_load();
        logic [7:0] c0;
        c0 = bus.store_cnt;
        issue(1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 8'h5A, 5'd3);
        n_vec = n_vec + 1;
        if (bus.reg_we_wb !== 1'b0 || bus.store_cnt !== c0 + 8'd1) begin
            n_err = n_err + 1;
            $display("FAIL store: we=%b cnt=%h expected 0/%h", bus.reg_we_wb, bus.store_cnt, c0 + 8'd1);
        end
        issue(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 5'd4);
        n_vec = n_vec + 1;
        if (bus.ans_wb !== 8'h5A || bus.RW_wb !== 5'd4 || bus.reg_we_wb !== 1'b1) begin
            n_err = n_err + 1;
            $display("FAIL load: ans=%h rw=%0d we=%b expected 5a/4/1",
                     bus.ans_wb, bus.RW_wb, bus.reg_we_wb);
        end
        // Mem select without a load, and a load without mem select, both pass ans_ex.
        issue(1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 5'd5);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 5'd6);
    endtask

    task automatic test_alu_pass();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 8'h99, 5'd7);
        n_vec = n_vec + 1;
        if (bus.ans_wb !== 8'hC3 || bus.RW_wb !== 5'd7 || bus.fwd_valid !== 1'b1 ||
            bus.fwd_data !== 8'hC3) begin
            n_err = n_err + 1;
            $display("FAIL alu_pass: ans=%h rw=%0d fv=%b fd=%h expected c3/7/1/c3",
                     bus.ans_wb, bus.RW_wb, bus.fwd_valid, bus.fwd_data);
        end
    endtask

    task automatic test_io();
        issue(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h81, 5'd8);
        n_vec = n_vec + 1;
        if (bus.port_out !== 8'h81) begin
            n_err = n_err + 1;
            $display("FAIL io_out: port_out=%h expected 81", bus.port_out);
        end
        issue(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 5'd9);
        n_vec = n_vec + 1;
        if (bus.ans_wb === 8'h81) begin
            n_err = n_err + 1;
            $display("FAIL io_out_alias: load ff returned %h, must not be 81", bus.ans_wb);
        end
        bus.port_in = 8'h3C;
        issue(1'b0, 1'b1, 1'b0, 1'b1, 8'hFE, 8'h00, 5'd10);
        n_vec = n_vec + 1;
        if (bus.ans_wb !== 8'h3C) begin
            n_err = n_err + 1;
            $display("FAIL io_in: ans_wb=%h expected 3c", bus.ans_wb);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0);
        for (int i = 0; i < 256; i++) begin
            a = i[7:0];
            issue(1'b0, 1'b1, 1'b1, 1'b0, a, a ^ 8'h5C, a[4:0]);
            if (i == 254) begin
                n_vec = n_vec + 1;
                if (bus.store_cnt !== 8'hFF) begin
                    n_err = n_err + 1;
                    $display("FAIL cnt_ff: store_cnt=%h expected ff", bus.store_cnt);
                end
            end
        end
        n_vec = n_vec + 1;
        if (bus.store_cnt !== 8'h00) begin
            n_err = n_err + 1;
            $display("FAIL cnt_wrap: store_cnt=%h expected 00", bus.store_cnt);
        end
        for (int i = 0; i < 254; i++) begin
            a = i[7:0];
            issue(1'b0, 1'b1, 1'b0, 1'b1, a, 8'h00, a[4:0]);
        end
    endtask

    task automatic test_reset_midstream();
        issue(1'b0, 1'b1, 1'b1, 1'b0, 8'h40, 8'h77, 5'd11);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0);
        issue(1'b0, 1'b1, 1'b0, 1'b1, 8'h40, 8'h00, 5'd12);
        n_vec = n_vec + 1;
        if (bus.ans_wb !== 8'h77 || bus.store_cnt !== 8'h00) begin
            n_err = n_err + 1;
            $display("FAIL reset_mid: ans=%h cnt=%h expected 77/00", bus.ans_wb, bus.store_cnt);
        end
    endtask

    initial begin
        clk                = 1'b0;
        reset              = 1'b1;
        n_vec              = 0;
        n_err              = 0;
        known_m            = '0;
        port_m             = 8'h00;
        cnt_m              = 8'h00;
        bus.ans_ex         = 8'h00;
        bus.B_Bypass       = 8'h00;
        bus.mem_en_ex      = 1'b0;
        bus.mem_rw_ex      = 1'b0;
        bus.mem_mux_sel_ex = 1'b0;
        bus.RW_ex          = 5'd0;
        bus.port_in        = 8'h00;
        @(negedge clk);
        test_reset();
        test_store_load();
        test_alu_pass();
        test_io();
        test_back_to_back();
        test_reset_midstream();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
